// File: rtl/seq_div4.sv
// Multi-cycle unsigned restoring divider: one shift-subtract step per clock,
// quotient/remainder presented with a single-cycle done pulse.
module seq_div4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    // A kept partial remainder is always below the divisor, so its top bit
    // is known to be 0 and only WIDTH bits are stored.
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   b_inv;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    assign r_shift  = {r_reg, q_reg[WIDTH-1]};
    assign b_inv    = ~{1'b0, dsr_reg};
    assign carry[0] = 1'b1;

    // Trial subtraction as a + ~b + 1 on a ripple-carry chain, like the adder.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign diff[gi] = r_shift[gi] ^ b_inv[gi] ^ carry[gi];
            if (gi < WIDTH) begin : g_carry
                assign carry[gi+1] = (r_shift[gi] & b_inv[gi])
                                   | (r_shift[gi] & carry[gi])
                                   | (b_inv[gi]   & carry[gi]);
            end
        end
    endgenerate

    // diff[WIDTH] set means the subtraction went negative: restore.
    assign r_step = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_step = {q_reg[WIDTH-2:0], ~diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            r_reg         <= '0;
            q_reg         <= '0;
            dsr_reg       <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            r_reg         <= r_next;
            q_reg         <= q_next;
            dsr_reg       <= dsr_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        r_next         = r_reg;
        q_next         = q_reg;
        dsr_next       = dsr_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    dbz_next = 1'b0;
                    dsr_next = divisor;
                    if (divisor == '0) begin
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = RUN;
                        r_next     = '0;
                        q_next     = dividend;
                        cnt_next   = CW'(WIDTH);
                    end
                end
            end
            RUN: begin
                busy     = 1'b1;
                r_next   = r_step;
                q_next   = q_step;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next     = DONE;
                    quotient_next  = q_step;
                    remainder_next = r_step;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div4.sv
// Bench for seq_div4: cycle-level reference model built on / and %, compared
// every cycle, plus directed literal expectations.
module tb_seq_div4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_div4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted start produces its result 5 cycles later
    // (1 for divide-by-zero); nothing is accepted while a result is pending.
    int         m_left  = 0;
    logic       m_done  = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_q     = 4'd0;
    logic [3:0] m_r     = 4'd0;
    logic       m_dbz   = 1'b0;
    logic [3:0] p_q     = 4'd0;
    logic [3:0] p_r     = 4'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_q     <= 4'd0;
            m_r     <= 4'd0;
            m_dbz   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
            end
        end else if (start) begin
            if (divisor == 4'd0) begin
                m_done <= 1'b1;
                m_q    <= 4'hF;
                m_r    <= dividend;
                m_dbz  <= 1'b1;
            end else begin
                m_dbz  <= 1'b0;
                m_left <= 4;
                p_q    <= dividend / divisor;
                p_r    <= dividend % divisor;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",        8'(busy),        8'(m_left != 0));
            check("done",        8'(done),        8'(m_done));
            check("quotient",    8'(quotient),    8'(m_q));
            check("remainder",   8'(remainder),   8'(m_r));
            check("div_by_zero", 8'(div_by_zero), 8'(m_dbz));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_left != 0 || m_done) begin
            cycle();
            n++;
            if (n > 20) begin
                checks++;
                failures++;
                $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
                break;
            end
        end
    endtask

    task automatic do_div(input logic [3:0] a, input logic [3:0] b);
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        $display("start %0d / %0d", a, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        cycle();
        cycle();
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_q",    8'(quotient), 8'd0);
        check("rst_r",    8'(remainder), 8'd0);
        rst_n = 1'b1;
        cycle();

        // 13 / 3: busy right after start, done 5 cycles after start
        do_div(4'd13, 4'd3);
        check("t1_busy", 8'(busy), 8'd1);
        repeat (4) cycle();
        check("t1_done", 8'(done), 8'd1);
        check("t1_q",    8'(quotient), 8'd4);
        check("t1_r",    8'(remainder), 8'd1);
        check("t1_dbz",  8'(div_by_zero), 8'd0);
        check("t1_model_q", 8'(m_q), 8'd4);

        do_div(4'd15, 4'd1);
        repeat (4) cycle();
        check("t2a_q", 8'(quotient), 8'd15);
        check("t2a_r", 8'(remainder), 8'd0);
        do_div(4'd2, 4'd9);
        repeat (4) cycle();
        check("t2b_q", 8'(quotient), 8'd0);
        check("t2b_r", 8'(remainder), 8'd2);
        check("t2b_model_r", 8'(m_r), 8'd2);

        // divide by zero: done one cycle after start, never busy
        do_div(4'd7, 4'd0);
        check("t3_done", 8'(done), 8'd1);
        check("t3_busy", 8'(busy), 8'd0);
        check("t3_q",    8'(quotient), 8'hF);
        check("t3_r",    8'(remainder), 8'd7);
        check("t3_dbz",  8'(div_by_zero), 8'd1);

        // start while busy is ignored
        do_div(4'd13, 4'd3);
        cycle();
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        repeat (2) cycle();
        check("t4a_done", 8'(done), 8'd1);
        check("t4a_q",    8'(quotient), 8'd4);
        check("t4a_r",    8'(remainder), 8'd1);
        do_div(4'd6, 4'd2);
        repeat (4) cycle();
        check("t4b_q", 8'(quotient), 8'd3);
        check("t4b_r", 8'(remainder), 8'd0);

        // reset mid-operation aborts without a done pulse
        do_div(4'd11, 4'd2);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("t5_busy", 8'(busy), 8'd0);
        check("t5_done", 8'(done), 8'd0);
        check("t5_q",    8'(quotient), 8'd0);
        check("t5_r",    8'(remainder), 8'd0);
        rst_n = 1'b1;
        repeat (6) cycle();
        do_div(4'd9, 4'd4);
        repeat (4) cycle();
        check("t5_q2", 8'(quotient), 8'd2);
        check("t5_r2", 8'(remainder), 8'd1);

        // every operand pair, back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(4'(a), 4'(b));
            end
        end
        wait_idle();
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
